// File: rtl/ras_ctrl.sv
// ras_ctrl: sequencer between the commit stage and a return-address stack.
//
// Each committed JAL/JALR is classified by its RISC-V link-register hints
// (x1/x5) into push, return (pop with compare), pop-then-push or nothing.
// The resulting stack operation is registered and appears on stk_* one
// cycle after the commit is accepted. Pushes that hit a full stack are
// counted in drop_cnt so the matching returns can be skipped unchecked
// instead of comparing against the wrong entry. A stack mismatch is turned
// into a held fault that software clears with fault_clr.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                enable; when low, accepted commits are ignored
//   commit_valid/ready commit handshake (see below)
//   is_jal, is_jalr   instruction kind
//   rd, rs1           destination and JALR base register
//   link_addr         pc+4, pushed on calls
//   tgt_addr          resolved JALR target, compared on returns
//   stk_ena/push/pop/ret/din/clr   registered stack command
//   stk_mismatch/full/empty        stack status
//   fault, fault_clr  held mismatch fault and its clear request
//   drop_cnt          pushes dropped on a full stack, not yet unwound
//   underflow_cnt     returns seen on an empty stack (saturating)
//   state_dbg         current FSM state, for observation only
//
// Handshake: a commit transfers on a rising clk edge where commit_valid and
// commit_ready are both high; commit_ready depends only on registered state
// and never on commit_valid, and the commit stage holds its fields stable
// while commit_valid is high.
module ras_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  commit_valid,
    output logic                  commit_ready,
    input  logic                  is_jal,
    input  logic                  is_jalr,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [DATA_WIDTH-1:0] link_addr,
    input  logic [DATA_WIDTH-1:0] tgt_addr,
    output logic                  stk_ena,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic                  stk_ret,
    output logic [DATA_WIDTH-1:0] stk_din,
    output logic                  stk_clr,
    input  logic                  stk_mismatch,
    input  logic                  stk_full,
    input  logic                  stk_empty,
    output logic                  fault,
    input  logic                  fault_clr,
    output logic [CNT_W-1:0]      drop_cnt,
    output logic [CNT_W-1:0]      underflow_cnt,
    output logic [1:0]            state_dbg
);

    // DEPTH is informational only: fullness is reported by the stack itself.
    if (DEPTH < 1) begin : g_depth_invalid
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PP2   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   pp_link_q, pp_link_d;
    logic                    ena_d, push_d, ret_d, clr_d;
    logic [DATA_WIDTH-1:0]   din_d;
    logic [CNT_W-1:0]        drop_d, under_d;

    logic link_rd, link_rs1;
    logic cls_push, cls_ret, cls_pp;
    logic accept;
    logic mismatch_hit;

    assign link_rd  = (rd  == 5'd1) || (rd  == 5'd5);
    assign link_rs1 = (rs1 == 5'd1) || (rs1 == 5'd5);

    assign commit_ready = (state_q == S_IDLE);
    assign fault        = (state_q == S_FAULT);
    assign state_dbg    = state_q;
    assign accept       = commit_valid & commit_ready & en;

    // The unchecked pop command is never produced by the hint table.
    assign stk_pop = 1'b0;

    // While stk_clr is out the stack still shows the old sticky mismatch;
    // ignoring it for that one cycle keeps a clear from re-faulting at once.
    assign mismatch_hit = stk_mismatch & ~stk_clr;

    // Link-register hint classification.
    always_comb begin
        cls_push = 1'b0;
        cls_ret  = 1'b0;
        cls_pp   = 1'b0;
        if (is_jal) begin
            cls_push = link_rd;
        end else if (is_jalr) begin
            if (link_rd && !link_rs1) begin
                cls_push = 1'b1;
            end else if (!link_rd && link_rs1) begin
                cls_ret = 1'b1;
            end else if (link_rd && link_rs1) begin
                if (rd == rs1) cls_push = 1'b1;
                else           cls_pp   = 1'b1;
            end
        end
    end

    // Next state, next stack command and next counters.
    always_comb begin
        state_d   = state_q;
        pp_link_d = pp_link_q;
        ena_d     = 1'b0;
        push_d    = 1'b0;
        ret_d     = 1'b0;
        clr_d     = 1'b0;
        din_d     = '0;
        drop_d    = drop_cnt;
        under_d   = underflow_cnt;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cls_push) begin
                        if (stk_full) begin
                            if (drop_cnt != CNT_MAX) drop_d = drop_cnt + CNT_ONE;
                        end else begin
                            ena_d  = 1'b1;
                            push_d = 1'b1;
                            din_d  = link_addr;
                        end
                    end else if (cls_ret || cls_pp) begin
                        // A return first unwinds a dropped push, if any:
                        // the stack never held that frame.
                        if (drop_cnt != '0) begin
                            drop_d = drop_cnt - CNT_ONE;
                        end else if (stk_empty) begin
                            if (underflow_cnt != CNT_MAX) under_d = underflow_cnt + CNT_ONE;
                        end else begin
                            ena_d = 1'b1;
                            ret_d = 1'b1;
                            din_d = tgt_addr;
                        end
                    end
                    if (cls_pp) begin
                        pp_link_d = link_addr;
                        state_d   = S_PP2;
                    end
                end
                if (mismatch_hit) state_d = S_FAULT;
            end

            S_PP2: begin
                if (mismatch_hit) begin
                    // Pending push is discarded.
                    state_d = S_FAULT;
                end else begin
                    state_d = S_IDLE;
                    // stk_ret still shows the pop issued this cycle; that pop
                    // frees a slot even though stk_full does not show it yet.
                    if (stk_ret || !stk_full) begin
                        ena_d  = 1'b1;
                        push_d = 1'b1;
                        din_d  = pp_link_q;
                    end else if (drop_cnt != CNT_MAX) begin
                        drop_d = drop_cnt + CNT_ONE;
                    end
                end
            end

            S_FAULT: begin
                if (fault_clr) begin
                    state_d = S_IDLE;
                    clr_d   = 1'b1;
                    drop_d  = '0;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (!en) begin
            drop_d  = drop_cnt;
            under_d = underflow_cnt;
            if (state_q == S_FAULT && fault_clr) drop_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pp_link_q     <= '0;
            stk_ena       <= 1'b0;
            stk_push      <= 1'b0;
            stk_ret       <= 1'b0;
            stk_din       <= '0;
            stk_clr       <= 1'b0;
            drop_cnt      <= '0;
            underflow_cnt <= '0;
        end else begin
            state_q       <= state_d;
            pp_link_q     <= pp_link_d;
            stk_ena       <= ena_d;
            stk_push      <= push_d;
            stk_ret       <= ret_d;
            stk_din       <= din_d;
            stk_clr       <= clr_d;
            drop_cnt      <= drop_d;
            underflow_cnt <= under_d;
        end
    end

endmodule
